sdram_bus_arbiter: RTL and testbench

- Sequences the shared 32-bit SDRAM bus (`bus_*` interface of `ip_sdram`) among three requesters: p0 = VDP video fetch, p1 = CPU/VRAM access, p2 = auxiliary (palette/DMA).
- Generates periodic refresh requests from an internal timer.
- Allows exactly one transaction in flight at a time.
- Routes read data back to the owning port.
- Sits between the VDP core ports and `ip_sdram`.

---
 rtl/sdram_arb_pkg.sv | 26 ++
 rtl/sdram_refresh_timer.sv | 40 ++++
 rtl/sdram_bus_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_sdram_bus_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and constants for the SDRAM bus arbiter
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        GAP
    } arb_state_e;

    localparam int P_VDP   = 0;
    localparam int P_CPU   = 1;
    localparam int P_AUX   = 2;
    localparam int N_PORTS = 3;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

    function automatic logic [N_PORTS-1:0] port_onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// rtl/sdram_refresh_timer.sv - free-running refresh interval counter with a single pending flag
module sdram_refresh_timer #(
    parameter int INTERVAL = 512
) (
    input  logic clk,
    input  logic reset_n,
    input  logic hold_i,
    input  logic clear_i,
    output logic pending_o
);

    localparam int CW = $clog2(INTERVAL);

    logic [CW-1:0] cnt_q;
    logic          pending_q;
    logic          expire;

    assign expire    = !hold_i && (cnt_q == CW'(INTERVAL - 1));
    assign pending_o = pending_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            if (hold_i || expire) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
            // A fresh expiry outranks the clear so a refresh is never lost.
            if (expire) begin
                pending_q <= 1'b1;
            end else if (clear_i) begin
                pending_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sdram_bus_arbiter.sv
// rtl/sdram_bus_arbiter.sv - single-transaction arbiter of the shared SDRAM bus across three ports
module sdram_bus_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int REFRESH_INTERVAL = 512,
    parameter int GAP_CYCLES       = 1,
    parameter int READ_TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  req_valid,
    input  logic [2:0]  req_write,
    input  logic [62:0] req_address,
    input  logic [95:0] req_wdata,
    input  logic [11:0] req_wdata_mask,
    output logic [2:0]  req_ack,
    output logic [31:0] port_rdata,
    output logic [2:0]  port_rdata_en,
    output logic        read_timeout_err,
    input  logic        sdram_init_busy,
    output logic [20:0] bus_address,
    output logic        bus_valid,
    output logic        bus_write,
    output logic        bus_refresh,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wdata_mask,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rdata_en
);

    localparam int TW = $clog2(READ_TIMEOUT + 1);
    localparam arb_state_e POST_ST = (GAP_CYCLES == 0) ? IDLE : GAP;

    arb_state_e          state_q;
    logic [1:0]          owner_q;
    logic                is_read_q;
    logic                rr_q;          // 0 favours p1, 1 favours p2
    logic [TW-1:0]       to_cnt_q;
    logic [3:0]          gap_cnt_q;
    logic                timeout_err_q;
    logic [N_PORTS-1:0]  req_ack_q;
    logic                bus_valid_q;
    logic                bus_write_q;
    logic                bus_refresh_q;
    logic [ADDR_W-1:0]   bus_address_q;
    logic [DATA_W-1:0]   bus_wdata_q;
    logic [MASK_W-1:0]   bus_wdata_mask_q;

    logic [ADDR_W-1:0]   addr_a [N_PORTS];
    logic [DATA_W-1:0]   wdata_a [N_PORTS];
    logic [MASK_W-1:0]   mask_a [N_PORTS];

    logic                refresh_pending;
    logic                grant_valid;
    logic                grant_refresh;
    logic [1:0]          grant_idx;
    logic                rd_done;
    logic                rd_timeout;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_unpack
        assign addr_a[i]  = req_address[i*ADDR_W +: ADDR_W];
        assign wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
        assign mask_a[i]  = req_wdata_mask[i*MASK_W +: MASK_W];
    end

    sdram_refresh_timer #(
        .INTERVAL (REFRESH_INTERVAL)
    ) u_refresh_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .hold_i    (sdram_init_busy),
        .clear_i   ((state_q == IDLE) && grant_refresh),
        .pending_o (refresh_pending)
    );

    // Priority: refresh, then video fetch, then round-robin between CPU and aux.
    always_comb begin
        grant_valid   = 1'b0;
        grant_refresh = 1'b0;
        grant_idx     = 2'(P_VDP);
        if (!sdram_init_busy) begin
            if (refresh_pending) begin
                grant_valid   = 1'b1;
                grant_refresh = 1'b1;
            end else if (req_valid[P_VDP]) begin
                grant_valid = 1'b1;
                grant_idx   = 2'(P_VDP);
            end else if (req_valid[P_CPU] && (!rr_q || !req_valid[P_AUX])) begin
                grant_valid = 1'b1;
                grant_idx   = 2'(P_CPU);
            end else if (req_valid[P_AUX]) begin
                grant_valid = 1'b1;
                grant_idx   = 2'(P_AUX);
            end
        end
    end

    assign rd_done    = (state_q == WAIT_RD) && bus_rdata_en;
    assign rd_timeout = (state_q == WAIT_RD) && !bus_rdata_en
                        && (to_cnt_q == TW'(READ_TIMEOUT - 1));

    assign port_rdata_en    = (rd_done || rd_timeout) ? port_onehot(owner_q) : '0;
    assign port_rdata       = rd_timeout ? TIMEOUT_DATA : bus_rdata;
    assign req_ack          = req_ack_q;
    assign read_timeout_err = timeout_err_q;
    assign bus_valid        = bus_valid_q;
    assign bus_write        = bus_write_q;
    assign bus_refresh      = bus_refresh_q;
    assign bus_address      = bus_address_q;
    assign bus_wdata        = bus_wdata_q;
    assign bus_wdata_mask   = bus_wdata_mask_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            owner_q          <= '0;
            is_read_q        <= 1'b0;
            rr_q             <= 1'b0;
            to_cnt_q         <= '0;
            gap_cnt_q        <= '0;
            timeout_err_q    <= 1'b0;
            req_ack_q        <= '0;
            bus_valid_q      <= 1'b0;
            bus_write_q      <= 1'b0;
            bus_refresh_q    <= 1'b0;
            bus_address_q    <= '0;
            bus_wdata_q      <= '0;
            bus_wdata_mask_q <= 4'hF;
        end else begin
            req_ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        state_q       <= ISSUE;
                        owner_q       <= grant_idx;
                        is_read_q     <= !grant_refresh && !req_write[grant_idx];
                        bus_valid_q   <= 1'b1;
                        bus_refresh_q <= grant_refresh;
                        bus_write_q   <= !grant_refresh && req_write[grant_idx];
                        if (!grant_refresh) begin
                            bus_address_q    <= addr_a[grant_idx];
                            bus_wdata_q      <= wdata_a[grant_idx];
                            bus_wdata_mask_q <= mask_a[grant_idx];
                            req_ack_q        <= port_onehot(grant_idx);
                            if (grant_idx == 2'(P_CPU)) begin
                                rr_q <= 1'b1;
                            end else if (grant_idx == 2'(P_AUX)) begin
                                rr_q <= 1'b0;
                            end
                        end
                    end
                end
                ISSUE: begin
                    bus_valid_q   <= 1'b0;
                    bus_write_q   <= 1'b0;
                    bus_refresh_q <= 1'b0;
                    to_cnt_q      <= '0;
                    gap_cnt_q     <= '0;
                    state_q       <= is_read_q ? WAIT_RD : POST_ST;
                end
                WAIT_RD: begin
                    if (rd_done) begin
                        state_q <= POST_ST;
                    end else if (rd_timeout) begin
                        state_q       <= POST_ST;
                        timeout_err_q <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt_q == 4'(GAP_CYCLES - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_bus_arbiter.sv
// tb/tb_sdram_bus_arbiter.sv - scoreboard bench for sdram_bus_arbiter with a simple SDRAM model
module tb_sdram_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [2:0]  req_write = '0;
    logic [62:0] req_address = '0;
    logic [95:0] req_wdata = '0;
    logic [11:0] req_wdata_mask = '0;
    logic [2:0]  req_ack;
    logic [31:0] port_rdata;
    logic [2:0]  port_rdata_en;
    logic        read_timeout_err;
    logic        sdram_init_busy = 1'b1;
    logic [20:0] bus_address;
    logic        bus_valid;
    logic        bus_write;
    logic        bus_refresh;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wdata_mask;
    logic [31:0] bus_rdata;
    logic        bus_rdata_en;

    logic [31:0] mem [0:1023];
    logic [31:0] model_data_q = 32'h1234_5678;
    logic        model_en_q = 1'b0;
    logic        rd_off = 1'b0;
    logic        force_en = 1'b0;

    typedef struct {
        int          port;
        logic        wr;
        logic [20:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } grant_t;
    typedef struct {
        int          port;
        logic [31:0] data;
    } rd_t;

    grant_t exp_g[$];
    rd_t    exp_r[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_ref = -1;
    int n_ref = 0;
    logic phase_ref = 1'b0;

    always #5 clk = ~clk;

    sdram_bus_arbiter #(
        .REFRESH_INTERVAL (16),
        .GAP_CYCLES       (1),
        .READ_TIMEOUT     (8)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_write        (req_write),
        .req_address      (req_address),
        .req_wdata        (req_wdata),
        .req_wdata_mask   (req_wdata_mask),
        .req_ack          (req_ack),
        .port_rdata       (port_rdata),
        .port_rdata_en    (port_rdata_en),
        .read_timeout_err (read_timeout_err),
        .sdram_init_busy  (sdram_init_busy),
        .bus_address      (bus_address),
        .bus_valid        (bus_valid),
        .bus_write        (bus_write),
        .bus_refresh      (bus_refresh),
        .bus_wdata        (bus_wdata),
        .bus_wdata_mask   (bus_wdata_mask),
        .bus_rdata        (bus_rdata),
        .bus_rdata_en     (bus_rdata_en)
    );

    assign bus_rdata    = model_data_q;
    assign bus_rdata_en = model_en_q | force_en;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
    end

    // Simple SDRAM: writes land at the issue edge, read data returns one cycle later.
    always @(posedge clk) begin
        model_en_q <= 1'b0;
        if (bus_valid && !bus_refresh) begin
            if (bus_write) begin
                for (int b = 0; b < 4; b++)
                    if (!bus_wdata_mask[b]) mem[bus_address[9:0]][8*b +: 8] <= bus_wdata[8*b +: 8];
            end else if (!rd_off) begin
                model_en_q   <= 1'b1;
                model_data_q <= mem[bus_address[9:0]];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    task automatic set_port(input int p, input logic wr, input logic [20:0] a,
                            input logic [31:0] d, input logic [3:0] m);
        req_write[p]            = wr;
        req_address[p*21 +: 21] = a;
        req_wdata[p*32 +: 32]   = d;
        req_wdata_mask[p*4 +: 4] = m;
    endtask

    task automatic expect_grant(input int p, input logic wr, input logic [20:0] a,
                                input logic [31:0] d, input logic [3:0] m);
        grant_t g;
        g.port = p; g.wr = wr; g.addr = a; g.wdata = d; g.mask = m;
        exp_g.push_back(g);
    endtask

    task automatic expect_rd(input int p, input logic [31:0] d);
        rd_t r;
        r.port = p; r.data = d;
        exp_r.push_back(r);
    endtask

    task automatic wait_acks(input logic [2:0] ports, input int n, input string name);
        int got = 0;
        for (int c = 0; c < 600 && got < n; c++) begin
            @(negedge clk);
            if ((req_ack & ports) != 3'b000) got++;
        end
        check(name, got, n);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bus_valid"}, bus_valid, 0);
        check({tag, "_bus_write"}, bus_write, 0);
        check({tag, "_bus_refresh"}, bus_refresh, 0);
        check({tag, "_bus_address"}, bus_address, 0);
        check({tag, "_bus_wdata"}, bus_wdata, 0);
        check({tag, "_bus_wdata_mask"}, bus_wdata_mask, 4'hF);
        check({tag, "_req_ack"}, req_ack, 0);
        check({tag, "_port_rdata_en"}, port_rdata_en, 0);
        check({tag, "_timeout_err"}, read_timeout_err, 0);
    endtask

    // Monitor: compares every bus command and every read return against the queues.
    initial begin
        grant_t g;
        rd_t    r;
        int     d;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus_valid) begin
                if (bus_refresh) begin
                    check("refresh_no_ack", req_ack, 0);
                    check("refresh_write", bus_write, 0);
                    if (phase_ref) begin
                        n_ref++;
                        d = cyc - last_ref;
                        tests++;
                        if (last_ref < 0 || d < 12 || d > 20) begin
                            fails++;
                            $display("FAIL refresh_interval actual=%0d required=12..20", d);
                        end
                    end
                    last_ref = cyc;
                end else if (exp_g.size() == 0) begin
                    flag("unexpected_grant");
                end else begin
                    g = exp_g.pop_front();
                    check("grant_ack", req_ack, 3'b001 << g.port);
                    check("grant_write", bus_write, g.wr);
                    check("grant_address", bus_address, g.addr);
                    if (g.wr) begin
                        check("grant_wdata", bus_wdata, g.wdata);
                        check("grant_mask", bus_wdata_mask, g.mask);
                    end
                end
            end else if (bus_write || bus_refresh) begin
                flag("cmd_without_valid");
            end
            if (port_rdata_en != 3'b000) begin
                if (exp_r.size() == 0) begin
                    flag("unexpected_rdata");
                end else begin
                    r = exp_r.pop_front();
                    check("rdata_owner", port_rdata_en, 3'b001 << r.port);
                    check("rdata_value", port_rdata, r.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic any_act;
        int   k;
        logic seen;

        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        check("reset_rdata_passthrough", port_rdata, 32'h1234_5678);

        // Init hold: p1 write pending for 100 cycles while SDRAM initialises.
        set_port(1, 1'b1, 21'h00010, 32'hDEAD_BEEF, 4'b0101);
        expect_grant(1, 1'b1, 21'h00010, 32'hDEAD_BEEF, 4'b0101);
        req_valid[1] = 1'b1;
        reset_n = 1'b1;
        any_act = 1'b0;
        repeat (100) begin
            @(negedge clk);
            any_act = any_act | bus_valid | (|req_ack);
        end
        check("init_hold_quiet", any_act, 0);
        sdram_init_busy = 1'b0;
        @(negedge clk);
        check("init_release_ack", req_ack, 3'b010);
        req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);

        // Masked-write readback through port 1.
        set_port(1, 1'b0, 21'h00010, 32'h0, 4'h0);
        expect_grant(1, 1'b0, 21'h00010, 32'h0, 4'h0);
        expect_rd(1, 32'hDE00_BE00);
        req_valid[1] = 1'b1;
        wait_acks(3'b010, 1, "p1_read_ack");
        req_valid[1] = 1'b0;
        repeat (6) @(negedge clk);

        // All three read: p0 dominates, then p2/p1 alternate (p1 was granted last).
        set_port(0, 1'b0, 21'h00010, 32'h0, 4'h0);
        set_port(1, 1'b0, 21'h00011, 32'h0, 4'h0);
        set_port(2, 1'b0, 21'h00012, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            expect_grant(0, 1'b0, 21'h00010, 32'h0, 4'h0);
            expect_rd(0, 32'hDE00_BE00);
        end
        for (int i = 0; i < 2; i++) begin
            expect_grant(2, 1'b0, 21'h00012, 32'h0, 4'h0);
            expect_rd(2, 32'h0);
            expect_grant(1, 1'b0, 21'h00011, 32'h0, 4'h0);
            expect_rd(1, 32'h0);
        end
        req_valid = 3'b111;
        wait_acks(3'b001, 4, "p0_burst_acks");
        req_valid[0] = 1'b0;
        wait_acks(3'b110, 4, "rr_burst_acks");
        req_valid = 3'b000;
        repeat (8) @(negedge clk);

        // Continuous p0 traffic: refresh must still break in periodically.
        phase_ref = 1'b1;
        for (int i = 0; i < 20; i++) begin
            expect_grant(0, 1'b0, 21'h00010, 32'h0, 4'h0);
            expect_rd(0, 32'hDE00_BE00);
        end
        req_valid[0] = 1'b1;
        wait_acks(3'b001, 20, "p0_stream_acks");
        req_valid[0] = 1'b0;
        phase_ref = 1'b0;
        check("refresh_count_ge4", (n_ref >= 4), 1);
        repeat (4) @(negedge clk);

        // Read timeout: SDRAM never answers.
        rd_off = 1'b1;
        set_port(1, 1'b0, 21'h00010, 32'h0, 4'h0);
        expect_grant(1, 1'b0, 21'h00010, 32'h0, 4'h0);
        expect_rd(1, 32'hFFFF_FFFF);
        req_valid[1] = 1'b1;
        wait_acks(3'b010, 1, "timeout_read_ack");
        req_valid[1] = 1'b0;
        k = 0;
        seen = 1'b0;
        while (k < 20 && !seen) begin
            @(negedge clk);
            k++;
            if (port_rdata_en != 3'b000) seen = 1'b1;
        end
        check("timeout_latency", k, 8);
        @(negedge clk);
        check("timeout_err_set", read_timeout_err, 1);
        repeat (20) @(negedge clk);
        check("timeout_err_sticky", read_timeout_err, 1);

        // Reset in WAIT_RD, then a stale bus_rdata_en must be ignored.
        set_port(1, 1'b0, 21'h00011, 32'h0, 4'h0);
        expect_grant(1, 1'b0, 21'h00011, 32'h0, 4'h0);
        req_valid[1] = 1'b1;
        wait_acks(3'b010, 1, "abort_read_ack");
        req_valid[1] = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        reset_n = 1'b1;
        #2 force_en = 1'b1;
        @(negedge clk);
        check("late_rdata_ignored", port_rdata_en, 0);
        force_en = 1'b0;
        rd_off = 1'b0;

        repeat (10) @(negedge clk);
        check("grant_queue_drained", exp_g.size(), 0);
        check("rdata_queue_drained", exp_r.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
